// File: rtl/fault_pkg.sv
// Shared types and constants for the fault-injection campaign controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the FSM state encodings, the per-fault result record and a saturation
// helper. GID_W/NFAULTS describe the default 128-gate / 16-exercised build.
// Record fields are wide enough for any legal configuration. The top slices
// them down to its own port widths.
package fault_pkg;

  localparam int NG_DEF        = 128;
  localparam int NUM_GATES_DEF = 16;
  localparam int GID_W         = $clog2(NG_DEF);
  localparam int NFAULTS       = 2 * NUM_GATES_DEF;

  localparam int REC_GID_W = 16;
  localparam int REC_CNT_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_APPLY  = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_SAMPLE = 3'd3;
  localparam state_t ST_REPORT = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  typedef struct packed {
    logic [REC_GID_W-1:0] gid;
    logic                 val;
    logic [REC_CNT_W-1:0] mm_cnt;
  } res_rec_t;

  // All-ones value of a cnt_w-bit counter, held in a record-width word.
  function automatic logic [REC_CNT_W-1:0] cnt_sat(input int cnt_w);
    cnt_sat = REC_CNT_W'((64'd1 << cnt_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fault_stim_gen.sv
// Exhaustive stimulus counter plus settle timer for the fault campaign.
// Latency: stim updates on the clock after step_i/clear_i.
// Backpressure: none. The stimulus counter holds whenever step_i is low.
//
// Ports: clear_i zeroes stim (priority over step_i). step_i advances stim by 1.
//        settle_i runs the timer; settle_done_o flags its last settle cycle.
//        last_vec_o flags the all-ones terminal vector.
module fault_stim_gen #(
  parameter int IN_W       = 9,
  parameter int SETTLE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            step_i,
  input  logic            settle_i,
  output logic [IN_W-1:0] stim_o,
  output logic            last_vec_o,
  output logic            settle_done_o
);

  localparam int            TW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(SETTLE_CYC - 1);

  logic [IN_W-1:0] stim_q, stim_d;
  logic [TW-1:0]   tmr_q, tmr_d;

  assign settle_done_o = settle_i && (tmr_q == T_LAST);
  assign last_vec_o    = &stim_q;
  assign stim_o        = stim_q;

  always_comb begin
    stim_d = stim_q;
    if (clear_i)     stim_d = '0;
    else if (step_i) stim_d = stim_q + IN_W'(1);
  end

  // The timer counts only while settling and restarts from 0 for each vector.
  always_comb begin
    tmr_d = '0;
    if (settle_i && !settle_done_o) tmr_d = tmr_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_q <= '0;
      tmr_q  <= '0;
    end else begin
      stim_q <= stim_d;
      tmr_q  <= tmr_d;
    end
  end

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer: walks every (gate, stuck value) fault
// and sweeps every stimulus vector for it. It reports one mismatch record per fault.
// Latency: SETTLE_CYC+2 cycles per vector, plus the REPORT cycles for each fault.
// Backpressure: REPORT holds stable res_* and an idle fault bus until res_ready_i.
//
// Ports: start_i/abort_i control the campaign. stim_o/fault_en_bus_o/fault_val_o
//        drive the faulty and golden DUT copies. obs_faulty_i and obs_golden_i
//        return their outputs. res_* is the valid/ready result record.
//        det_cnt_o, busy_o and done_o report campaign status.
// Build option: FAULT_CTRL_EARLY_EXIT_EN ends a fault's sweep at the first mismatch.
module fault_campaign_ctrl
  import fault_pkg::*;
#(
  parameter int NG         = 128,
  parameter int GID_BASE   = 0,
  parameter int NUM_GATES  = 16,
  parameter int IN_W       = 9,
  parameter int DW         = 5,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_i,
  input  logic                               abort_i,
  output logic [IN_W-1:0]                    stim_o,
  output logic [NG-1:0]                      fault_en_bus_o,
  output logic                               fault_val_o,
  input  logic [DW-1:0]                      obs_faulty_i,
  input  logic [DW-1:0]                      obs_golden_i,
  output logic                               res_valid_o,
  input  logic                               res_ready_i,
  output logic [$clog2(NG)-1:0]              res_gid_o,
  output logic                               res_val_o,
  output logic [CNT_W-1:0]                   res_mm_cnt_o,
  output logic [$clog2(2*NUM_GATES+1)-1:0]   det_cnt_o,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int                   GW        = $clog2(NG);
  localparam int                   DCW       = $clog2(2 * NUM_GATES + 1);
  localparam logic [REC_GID_W-1:0] GID_FIRST = REC_GID_W'(GID_BASE);
  localparam logic [REC_GID_W-1:0] GID_LAST  = REC_GID_W'(GID_BASE + NUM_GATES - 1);
  localparam logic [REC_CNT_W-1:0] MM_SAT    = cnt_sat(CNT_W);

  state_t         state_q, state_d;
  res_rec_t       rec_q, rec_d;
  logic [DCW-1:0] det_q, det_d;
  logic           clear, step, last_vec, settle_done, mismatch, early_hit, fault_act;

  assign mismatch = (obs_faulty_i != obs_golden_i);

`ifdef FAULT_CTRL_EARLY_EXIT_EN
  assign early_hit = mismatch;
`else
  assign early_hit = 1'b0;
`endif

  fault_stim_gen #(
    .IN_W       (IN_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_stim (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear),
    .step_i        (step),
    .settle_i      (state_q == ST_SETTLE),
    .stim_o        (stim_o),
    .last_vec_o    (last_vec),
    .settle_done_o (settle_done)
  );

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    det_d   = det_q;
    clear   = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d      = ST_APPLY;
          det_d        = '0;
          rec_d.gid    = GID_FIRST;
          rec_d.val    = 1'b0;
          rec_d.mm_cnt = '0;
          clear        = 1'b1;
        end
      end
      ST_APPLY:  state_d = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        if (mismatch && (rec_q.mm_cnt != MM_SAT)) rec_d.mm_cnt = rec_q.mm_cnt + REC_CNT_W'(1);
        if (last_vec || early_hit) begin
          state_d = ST_REPORT;
        end else begin
          step    = 1'b1;
          state_d = ST_APPLY;
        end
      end
      ST_REPORT: begin
        if (res_ready_i) begin
          if (rec_q.mm_cnt != '0) det_d = det_q + DCW'(1);
          clear        = 1'b1;
          rec_d.mm_cnt = '0;
          if (rec_q.val) begin
            rec_d.val = 1'b0;
            rec_d.gid = rec_q.gid + REC_GID_W'(1);
          end else begin
            rec_d.val = 1'b1;
          end
          state_d = (rec_q.val && (rec_q.gid == GID_LAST)) ? ST_DONE : ST_APPLY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over a same-cycle handshake: the record and det count stay as they were.
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      rec_d   = rec_q;
      det_d   = det_q;
      clear   = 1'b1;
      step    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rec_q   <= '0;
      det_q   <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      det_q   <= det_d;
    end
  end

  assign fault_act      = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign fault_en_bus_o = fault_act ? (NG'(1) << rec_q.gid) : '0;
  assign fault_val_o    = fault_act && rec_q.val;
  assign res_valid_o    = (state_q == ST_REPORT);
  assign res_gid_o      = rec_q.gid[GW-1:0];
  assign res_val_o      = rec_q.val;
  assign res_mm_cnt_o   = rec_q.mm_cnt[CNT_W-1:0];
  assign det_cnt_o      = det_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);

endmodule
